// File: rtl/burst_address_sequencer.sv
// burst_address_sequencer: emits one burst of wrap/linear beat addresses over a valid/ready handshake.
// Optional start-request alignment checking is enabled by defining ALIGN_CHECK_EN.
module burst_address_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int SIZE_WIDTH = 3,
    parameter int PAGE_BEATS = 256
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Start,
    input  logic [ADDR_WIDTH-1:0] StartAddr,
    input  logic [SIZE_WIDTH-1:0] SizeIn,
    input  logic                  AddrMode,
    input  logic [2:0]            BurstLengthConfig,
    input  logic                  Abort,
    input  logic                  AddrReady,
    output logic [ADDR_WIDTH-1:0] AddrOut,
    output logic                  AddrValid,
    output logic                  LastBeat,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error
);
    localparam int CW = $clog2(PAGE_BEATS) + 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] mask_q, mask_d;
    logic [SIZE_WIDTH-1:0] size_q, size_d;
    logic                  lin_q, lin_d;
    logic [CW-1:0]         left_q, left_d;
    logic [CW-1:0]         beats;
    logic [CW+SIZE_WIDTH-1:0] w_full;
    logic [ADDR_WIDTH-1:0] sum, next_addr;
    logic                  reject;

    assign beats  = (BurstLengthConfig == 3'b111) ? CW'(PAGE_BEATS) : CW'(1) << BurstLengthConfig;
    assign w_full = {{SIZE_WIDTH{1'b0}}, beats} * {{CW{1'b0}}, SizeIn};
    // A window that covers the whole address space degenerates to plain linear stepping.
    assign sum       = addr_q + ADDR_WIDTH'(size_q);
    assign next_addr = lin_q ? sum : (addr_q & ~mask_q) | (sum & mask_q);

`ifdef ALIGN_CHECK_EN
    logic err_q;
    assign reject = !(SizeIn == SIZE_WIDTH'(1) || SizeIn == SIZE_WIDTH'(2) || SizeIn == SIZE_WIDTH'(4))
                    || |(StartAddr & (ADDR_WIDTH'(SizeIn) - ADDR_WIDTH'(1)));
    assign Error  = err_q;
    always_ff @(posedge Clk) begin
        if (!Reset_n) err_q <= 1'b0;
        else          err_q <= (state_q == IDLE) && Start && reject;
    end
`else
    assign reject = 1'b0;
    assign Error  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        size_d  = size_q;
        lin_d   = lin_q;
        left_d  = left_q;
        case (state_q)
            IDLE: if (Start && !reject) begin
                state_d = BURST;
                addr_d  = StartAddr;
                size_d  = SizeIn;
                mask_d  = w_full[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
                lin_d   = AddrMode || ((w_full >> ADDR_WIDTH) != 0);
                left_d  = beats - CW'(1);
            end
            BURST: if (Abort) begin
                state_d = IDLE;
            end else if (AddrReady) begin
                if (left_q == 0) state_d = DONE;
                else begin
                    addr_d = next_addr;
                    left_d = left_q - CW'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            mask_q  <= '0;
            size_q  <= '0;
            lin_q   <= 1'b0;
            left_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            size_q  <= size_d;
            lin_q   <= lin_d;
            left_q  <= left_d;
        end
    end

    assign AddrOut   = addr_q;
    assign AddrValid = (state_q == BURST);
    assign LastBeat  = AddrValid && (left_q == 0);
    assign Busy      = (state_q != IDLE);
    assign Done      = (state_q == DONE);
endmodule

// File: tb/tb_burst_address_sequencer.sv
// tb_burst_address_sequencer: directed self-checking bench for burst_address_sequencer.
module tb_burst_address_sequencer;
    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Start = 1'b0;
    logic [7:0] StartAddr = '0;
    logic [2:0] SizeIn = '0;
    logic       AddrMode = 1'b0;
    logic [2:0] BurstLengthConfig = '0;
    logic       Abort = 1'b0;
    logic       AddrReady = 1'b0;
    logic [7:0] AddrOut;
    logic       AddrValid, LastBeat, Busy, Done, Error;
    int errors = 0;
    int checks = 0;

    burst_address_sequencer dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr), .SizeIn(SizeIn),
        .AddrMode(AddrMode), .BurstLengthConfig(BurstLengthConfig), .Abort(Abort),
        .AddrReady(AddrReady), .AddrOut(AddrOut), .AddrValid(AddrValid), .LastBeat(LastBeat),
        .Busy(Busy), .Done(Done), .Error(Error)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_burst(input logic [7:0] a, input logic [2:0] s, input logic m, input logic [2:0] c);
        StartAddr = a;
        SizeIn = s;
        AddrMode = m;
        BurstLengthConfig = c;
        Start = 1'b1;
        step();
        Start = 1'b0;
        StartAddr = 8'hAA;
        SizeIn = 3'd1;
        BurstLengthConfig = 3'b000;
    endtask

    task automatic chk_beat(input string tag, input logic [7:0] a, input logic last);
        chk({tag, "_addr"}, AddrOut, a);
        chk({tag, "_valid"}, AddrValid, 1'b1);
        chk({tag, "_last"}, LastBeat, last);
        chk({tag, "_done"}, Done, 1'b0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, AddrValid, 1'b0);
        chk({tag, "_busy"}, Busy, 1'b0);
        chk({tag, "_done"}, Done, 1'b0);
        chk({tag, "_last"}, LastBeat, 1'b0);
    endtask

    initial begin
        logic [7:0] lin_exp [4];
        logic [7:0] wrap_exp [4];
        int done_seen;
        lin_exp  = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        wrap_exp = '{8'h35, 8'h36, 8'h37, 8'h34};

        step();
        step();
        chk("rst_addr", AddrOut, 8'h00);
        chk_idle("rst");
        chk("rst_err", Error, 1'b0);
        Reset_n = 1'b1;
        AddrReady = 1'b1;
        step();

        start_burst(8'h0C, 3'd4, 1'b0, 3'b010);
        chk("seq_busy", Busy, 1'b1);
        chk_beat("seq0", 8'h0C, 1'b0);
        step();
        chk_beat("seq1", 8'h00, 1'b0);
        step();
        chk_beat("seq2", 8'h04, 1'b0);
        step();
        chk_beat("seq3", 8'h08, 1'b1);
        step();
        chk("seq_done", Done, 1'b1);
        chk("seq_done_valid", AddrValid, 1'b0);
        chk("seq_done_busy", Busy, 1'b1);
        step();
        chk_idle("seq_end");

        start_burst(8'hFE, 3'd1, 1'b1, 3'b010);
        for (int i = 0; i < 4; i++) begin
            chk_beat("lin", lin_exp[i], i == 3);
            step();
        end
        chk("lin_done", Done, 1'b1);
        step();
        chk_idle("lin_end");

        start_burst(8'h35, 3'd1, 1'b0, 3'b010);
        for (int i = 0; i < 4; i++) begin
            chk_beat("wrap", wrap_exp[i], i == 3);
            step();
        end
        chk("wrap_done", Done, 1'b1);
        step();

        AddrReady = 1'b0;
        start_burst(8'h10, 3'd2, 1'b0, 3'b001);
        for (int i = 0; i < 3; i++) begin
            chk_beat("bp_hold", 8'h10, 1'b0);
            StartAddr = 8'h80;
            Start = 1'b1;
            step();
            Start = 1'b0;
        end
        AddrReady = 1'b1;
        chk_beat("bp_rel", 8'h10, 1'b0);
        step();
        chk_beat("bp1", 8'h12, 1'b1);
        step();
        chk("bp_done", Done, 1'b1);
        StartAddr = 8'h80;
        Start = 1'b1;
        step();
        Start = 1'b0;
        chk_idle("bp_start_in_done");
        step();
        chk_idle("bp_end");

        start_burst(8'h20, 3'd1, 1'b0, 3'b011);
        step();
        step();
        step();
        chk_beat("abort_pre", 8'h23, 1'b0);
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        chk_idle("abort");
        step();
        chk_idle("abort_after");
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        chk_idle("abort_in_idle");

        start_burst(8'h20, 3'd1, 1'b0, 3'b011);
        step();
        step();
        step();
        chk_beat("rstmid_pre", 8'h23, 1'b0);
        Reset_n = 1'b0;
        step();
        chk("rstmid_addr", AddrOut, 8'h00);
        chk_idle("rstmid");
        Reset_n = 1'b1;
        step();
        chk_idle("rstmid_after");

        start_burst(8'h00, 3'd1, 1'b0, 3'b111);
        done_seen = 0;
        for (int i = 0; i < 256; i++) begin
            chk("page_addr", AddrOut, i[7:0]);
            chk("page_last", LastBeat, i == 255);
            if (Done) done_seen++;
            step();
        end
        chk("page_done", Done, 1'b1);
        step();
        chk("page_done_once", done_seen, 0);
        chk_idle("page_end");

`ifdef ALIGN_CHECK_EN
        start_burst(8'h03, 3'd4, 1'b1, 3'b010);
        chk("align_err", Error, 1'b1);
        chk_idle("align");
        step();
        chk("align_err_pulse", Error, 1'b0);
        start_burst(8'h00, 3'd3, 1'b1, 3'b010);
        chk("size_err", Error, 1'b1);
        chk_idle("size");
`else
        start_burst(8'h03, 3'd4, 1'b1, 3'b001);
        chk("noalign_err", Error, 1'b0);
        chk_beat("noalign0", 8'h03, 1'b0);
        step();
        chk_beat("noalign1", 8'h07, 1'b1);
        step();
        chk("noalign_done", Done, 1'b1);
`endif
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/burst_address_sequencer.md
Name: burst_address_sequencer

Overview:
Sequences one memory burst. On a Start request it latches the start address, the increment size, the address mode and the burst-length configuration. It then emits one address per beat through a valid/ready handshake and signals Done after the last beat. It sits between the bus-interface command decoder and the SDRAM command/address path, and produces the same wrap/linear address sequence as the codebase's address-generator arithmetic.

Parameters:
ADDR_WIDTH, 8, address width; all address arithmetic is modulo 2^ADDR_WIDTH.
SIZE_WIDTH, 3, width of the per-beat increment.
PAGE_BEATS, 256, beat count for burst config 3'b111 (page burst).

Ports:
Clk  input  1  clock, rising edge.
Reset_n  input  1  synchronous active-low reset.
Start  input  1  burst request; accepted only in IDLE.
StartAddr  input  ADDR_WIDTH  first beat address.
SizeIn  input  SIZE_WIDTH  per-beat increment; legal values 1, 2, 4.
AddrMode  input  1  0 = sequential (wrap within burst window), 1 = linear.
BurstLengthConfig  input  3  000=1, 001=2, 010=4, 011=8, 100=16, 101=32, 110=64, 111=PAGE_BEATS beats.
Abort  input  1  terminate the active burst.
AddrReady  input  1  downstream accepts the current beat.
AddrOut  output  ADDR_WIDTH  current beat address.
AddrValid  output  1  AddrOut valid.
LastBeat  output  1  current beat is the final beat (qualified by AddrValid).
Busy  output  1  not in IDLE.
Done  output  1  one-cycle pulse after the final beat is accepted.
Error  output  1  one-cycle pulse on a rejected request (ALIGN_CHECK_EN only; tied 0 otherwise).

Behaviour:
- Reset (Reset_n=0 at a Clk edge) forces state IDLE. AddrOut=0, AddrValid=0, LastBeat=0, Busy=0, Done=0, Error=0, beat counter=0.
- Reset overrides everything, including a burst mid-flight. No Done is issued for a burst killed by reset.
- States: IDLE, BURST, DONE.
- IDLE:
  - Start=1 latches all config inputs and sets BeatsLeft = beats-1. The next state is BURST.
  - In the cycle after Start, AddrValid=1 and AddrOut=StartAddr.
- BURST:
  - A beat transfers when AddrValid & AddrReady.
  - While AddrReady=0, AddrOut and LastBeat stay stable.
  - On a transfer with BeatsLeft>0: AddrOut <= NextAddr, BeatsLeft decrements, AddrValid stays 1 (back-to-back beats, one per cycle).
  - On a transfer with BeatsLeft==0 (LastBeat=1): the next state is DONE and AddrValid drops.
- DONE: Done=1 for exactly one cycle, then IDLE. A Start arriving in DONE is ignored.
- Start while Busy=1 is ignored. Inputs other than Start are don't-care outside the Start cycle.
- Abort in BURST: next state is IDLE, AddrValid=0, no Done. A beat transferring in the same cycle as Abort counts as accepted, but the burst still ends. Abort in IDLE or DONE has no effect.
- Address arithmetic:
  - Window W = beats × SizeIn, truncated to 2^ADDR_WIDTH; M = W-1.
  - Linear mode, or W ≥ 2^ADDR_WIDTH: NextAddr = AddrOut + SizeIn, modulo 2^ADDR_WIDTH.
  - Sequential mode: NextAddr = (AddrOut & ~M) | ((AddrOut + SizeIn) & M). Upper address bits never change within the burst.
  - Beats=1: no increment occurs; LastBeat=1 on the first beat.
- LastBeat = AddrValid & (BeatsLeft==0).
- The beat counter is wide enough for PAGE_BEATS-1 (9 bits at default).

Optional Feature:
ALIGN_CHECK_EN
- Defined: a Start is rejected when SizeIn ∉ {1,2,4}, or when StartAddr is not a multiple of SizeIn. On rejection Error pulses 1 cycle later and the state stays IDLE (Busy=0, AddrValid=0).
- Undefined: no checks are made, Error is tied 0, and every Start in IDLE is accepted with the arithmetic above.

Test Plan:
- Sequential wrap: Start, StartAddr=0x0C, SizeIn=4, AddrMode=0, cfg=010, AddrReady=1 → AddrOut 0x0C,0x00,0x04,0x08 on consecutive cycles; LastBeat on 0x08; Done the following cycle.
- Linear rollover: StartAddr=0xFE, SizeIn=1, AddrMode=1, cfg=010 → 0xFE,0xFF,0x00,0x01; Done after 4 beats.
- Backpressure: cfg=001, StartAddr=0x10, SizeIn=2, AddrReady low for 3 cycles on beat 0 → 0x10 held stable with AddrValid=1; then 0x12; Done; Start pulsed while Busy is ignored.
- Abort / reset mid-burst: cfg=011, Abort asserted after the 3rd transfer → IDLE next cycle, no Done. Repeat with Reset_n=0 instead → all outputs 0, no Done.
- Page burst: cfg=111, SizeIn=1, StartAddr=0x00, AddrMode=0 → 256 beats 0x00..0xFF, LastBeat on 0xFF, Done once.
- ALIGN_CHECK_EN: StartAddr=0x03, SizeIn=4 → Error pulse, Busy stays 0. SizeIn=3 → Error. Without the macro, the same stimulus starts a burst at 0x03.
